// File: rtl/sw_pkg.sv
// Shared switch definitions: lane/payload widths and the buffered-entry layout.
package sw_pkg;
  localparam int N_PORTS   = 8;
  localparam int PAYLOAD_W = 32;
  localparam int LANE_W    = 3;

  typedef logic [LANE_W-1:0]    lane_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  typedef struct packed {
    lane_t    src;
    payload_t data;
  } entry_t;
endpackage

// File: rtl/rr_arb8.sv
// Combinational 8-way round-robin picker: first requester after `last`, wrapping.
// Zero latency; grant_vld low when no request is present.
module rr_arb8
  import sw_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  lane_t              last,
  output logic [N_PORTS-1:0] grant,
  output lane_t              grant_idx,
  output logic               grant_vld
);

  lane_t cand;

  always_comb begin
    grant     = '0;
    grant_idx = last;
    grant_vld = 1'b0;
    cand      = last;
    // Offset 8 wraps back onto `last` itself, so it has lowest standing.
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = last + lane_t'(k);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/out_port_arb.sv
// Output-port arbiter: round-robin over 8 lanes into a DEPTH-entry FIFO, head shown unregistered (1-cycle latency).
// Grants drop to zero when the FIFO is full; OUT_PORT_ARB_PRIO_EN restricts the eligible set to prioritised lanes.
module out_port_arb
  import sw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           req_valid,
  input  logic [N_PORTS*PAYLOAD_W-1:0] req_payload,
  input  logic [N_PORTS-1:0]           req_prio,
  output logic [N_PORTS-1:0]           req_ready,
  output logic                         out_valid,
  output payload_t                     out_payload,
  output lane_t                        out_src,
  input  logic                         out_ready,
  output logic [CW-1:0]                fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] ptr_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  lane_t         last_q, last_d;

  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] grant;
  lane_t              grant_idx;
  logic               grant_vld;
  logic               full;
  logic               push;
  logic               pop;
  payload_t           push_data;

`ifdef OUT_PORT_ARB_PRIO_EN
  logic [N_PORTS-1:0] prio_req;

  always_comb begin
    prio_req = req_valid & req_prio;
    elig     = (prio_req != '0) ? prio_req : req_valid;
  end
`else
  logic unused_prio;

  assign unused_prio = ^req_prio;
  assign elig        = req_valid;
`endif

  rr_arb8 u_rr (
    .req       (elig),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Full blocks grants even if a pop is due, keeping ready off the out_ready path.
  assign full      = (count_q == CW'(DEPTH));
  assign req_ready = (rst || full) ? '0 : grant;
  assign push      = grant_vld && !full && !rst;
  assign pop       = out_valid && out_ready;
  assign push_data = req_payload[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{src: grant_idx, data: push_data};
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
      last_d          = grant_idx;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= lane_t'(N_PORTS - 1);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign out_valid   = (count_q != '0);
  assign out_payload = mem_q[rd_ptr_q].data;
  assign out_src     = mem_q[rd_ptr_q].src;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_out_port_arb.sv
// Bench for out_port_arb: queue-based reference model with scoreboard monitor on the output side.
module tb_out_port_arb;
  import sw_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     req_valid;
  logic [255:0]   req_payload;
  logic [7:0]     req_prio;
  logic [7:0]     req_ready;
  logic           out_valid;
  logic [31:0]    out_payload;
  logic [2:0]     out_src;
  logic           out_ready;
  logic [CW-1:0]  fifo_count;

  out_port_arb #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_payload (req_payload),
    .req_prio    (req_prio),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [7:0]  hold_v;
  logic [31:0] hold_p [8];
  logic [7:0]  hold_pr;
  int          mlast;
  bit          pend_vld;
  exp_t        pend;
  int          dut_acc [8];
  int          snap [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] elig, input int last);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (last + k) % 8;
      if (elig[l]) return l;
    end
    return -1;
  endfunction

  // One clock of stimulus: commit last accept, refill lanes, predict and check the grant.
  task automatic step(input logic [7:0] mask, input int prob, input logic [7:0] pmask,
                      input int ordy, input bit pat);
    logic [7:0] elig;
    logic [7:0] exp_rdy;
    int         g;
    @(posedge clk);
    #1;
    if (pend_vld) begin
      sbq.push_back(pend);
      hold_v[pend.src] = 1'b0;
      pend_vld = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (!hold_v[i] && mask[i] && $urandom_range(99) < prob) begin
        hold_v[i]  = 1'b1;
        hold_p[i]  = pat ? (32'hA000_0000 | (32'(i) << 24) | 32'(i)) : $urandom;
        hold_pr[i] = pmask[i];
      end
      req_payload[32*i +: 32] = hold_p[i];
    end
    req_valid = hold_v;
    req_prio  = hold_pr;
    out_ready = (ordy == 2) ? 1'($urandom_range(1)) : (ordy == 1);
    #3;
`ifdef OUT_PORT_ARB_PRIO_EN
    elig = ((hold_v & hold_pr) != 0) ? (hold_v & hold_pr) : hold_v;
`else
    elig = hold_v;
`endif
    g = pick(elig, mlast);
    exp_rdy = (sbq.size() == DEPTH || g < 0) ? 8'h00 : 8'(1 << g);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 8; i++) begin
      if (req_valid[i] && req_ready[i]) dut_acc[i]++;
    end
    if (exp_rdy != 0) begin
      pend     = '{g, hold_p[g]};
      pend_vld = 1'b1;
      mlast    = g;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 0, 8'h00, 1, 1'b0);
  endtask

  always @(negedge clk) begin
    chk("fifo_count", 32'(fifo_count), 32'(sbq.size()));
    chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk("out_payload", out_payload, sbq[0].data);
      chk("out_src", 32'(out_src), 32'(sbq[0].src));
      if (out_valid && out_ready) void'(sbq.pop_front());
    end
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 8'hFF;
    req_payload = '1;
    req_prio    = 8'h00;
    out_ready   = 1'b1;
    hold_v      = 8'h00;
    hold_pr     = 8'h00;
    mlast       = 7;
    pend_vld    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hold_p[i]  = 32'h0;
      dut_acc[i] = 0;
    end
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_payload", out_payload, 32'h0);
    chk("rst_src", 32'(out_src), 32'h0);
    req_valid = 8'h00;
    @(posedge clk);
    #2 rst = 1'b0;

    // Lanes 0 and 5 alternate from reset
    for (int i = 0; i < 4; i++) step(8'h21, 100, 8'h00, 1, 1'b1);
    drain(12);

    // All lanes: strict rotation, equal share over 64 accepts
    for (int i = 0; i < 8; i++) snap[i] = dut_acc[i];
    for (int i = 0; i < 64; i++) step(8'hFF, 100, 8'h00, 1, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_lane%0d", i), 32'(dut_acc[i] - snap[i]), 32'd8);
    drain(12);

    // Fill to full, single pop, then push+pop while full, then random drain-rate wrap
    for (int i = 0; i < 8; i++) step(8'h0C, 100, 8'h00, 0, 1'b0);
    step(8'h0C, 100, 8'h00, 1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h0C, 100, 8'h00, 0, 1'b0);
    for (int i = 0; i < 2; i++) step(8'h0C, 100, 8'h00, 1, 1'b0);
    for (int i = 0; i < 40; i++) step(8'h0C, 100, 8'h00, 2, 1'b0);
    drain(12);

    // Asynchronous reset with three words buffered
    for (int i = 0; i < 3; i++) step(8'h06, 100, 8'h00, 0, 1'b0);
    @(posedge clk);
    #1;
    if (pend_vld) begin
      sbq.push_back(pend);
      hold_v[pend.src] = 1'b0;
      pend_vld = 1'b0;
    end
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_count", 32'(fifo_count), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    sbq.delete();
    mlast     = 7;
    hold_v    = 8'h00;
    req_valid = 8'h00;
    @(posedge clk);
    #2 rst = 1'b0;
    step(8'h09, 100, 8'h00, 1, 1'b0);
    chk("post_rst_grant", 32'(pend.src), 32'd0);
    drain(12);

    // Priority lane 6 among 1,4,6, then lane 6 stops requesting
    for (int i = 0; i < 4; i++) step(8'h52, 100, 8'h40, 1, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h12, 100, 8'h00, 1, 1'b0);
    drain(12);

    // Random traffic, random priority and backpressure
    for (int i = 0; i < 400; i++) step(8'($urandom), 50, 8'($urandom), 2, 1'b0);
    drain(20);
    @(negedge clk);
    chk("final_count", 32'(fifo_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
